// File: rtl/nss_pkg.sv
// Shared types and constants for the nibble-serial subtractor.
package nss_pkg;

  localparam int unsigned NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_serial_subtractor_slice.sv
// Combinational 4-bit subtractor slice: {Borrow_out, Diff} = A - B - Borrow_in.
module Subtractor_4bit
  import nss_pkg::*;
(
  input  logic [NIBBLE_W-1:0] A,
  input  logic [NIBBLE_W-1:0] B,
  input  logic                Borrow_in,
  output logic [NIBBLE_W-1:0] Diff,
  output logic                Borrow_out
);

  // Bit NIBBLE_W of the widened difference is set exactly when the result underflows.
  assign {Borrow_out, Diff} = {1'b0, A} - {1'b0, B} - {{NIBBLE_W{1'b0}}, Borrow_in};

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Wide subtractor computing a - b - borrow_in one nibble per clock through a single
// 4-bit slice, with valid/ready handshakes on both operand and result sides.
module nibble_serial_subtractor
  import nss_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             borrow_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out,
  output logic             busy
);

  localparam int unsigned NIBBLES = WIDTH / NIBBLE_W;
  localparam int unsigned CntW    = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             borrow_q, borrow_d;
  logic             borrow_out_q, borrow_out_d;
  logic [CntW-1:0]  cnt_q, cnt_d;

  logic [NIBBLE_W-1:0]       slice_diff;
  logic                      slice_borrow;
  logic [WIDTH+NIBBLE_W-1:0] res_cat;

  Subtractor_4bit u_slice (
    .A          (a_sh_q[NIBBLE_W-1:0]),
    .B          (b_sh_q[NIBBLE_W-1:0]),
    .Borrow_in  (borrow_q),
    .Diff       (slice_diff),
    .Borrow_out (slice_borrow)
  );

  // New nibble enters at the MSB end; after NIBBLES shifts nibble 0 sits at the LSB.
  assign res_cat = {slice_diff, res_q};

  always_comb begin
    state_d      = state_q;
    a_sh_d       = a_sh_q;
    b_sh_d       = b_sh_q;
    res_d        = res_q;
    diff_d       = diff_q;
    borrow_d     = borrow_q;
    borrow_out_d = borrow_out_q;
    cnt_d        = cnt_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d   = a;
          b_sh_d   = b;
          borrow_d = borrow_in;
          cnt_d    = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        a_sh_d   = a_sh_q >> NIBBLE_W;
        b_sh_d   = b_sh_q >> NIBBLE_W;
        res_d    = res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
        borrow_d = slice_borrow;
        cnt_d    = cnt_q + CntW'(1);
        if (cnt_q == CntW'(NIBBLES - 1)) begin
          diff_d       = res_cat[WIDTH+NIBBLE_W-1:NIBBLE_W];
          borrow_out_d = slice_borrow;
          state_d      = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      a_sh_q       <= '0;
      b_sh_q       <= '0;
      res_q        <= '0;
      diff_q       <= '0;
      borrow_q     <= 1'b0;
      borrow_out_q <= 1'b0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      a_sh_q       <= a_sh_d;
      b_sh_q       <= b_sh_d;
      res_q        <= res_d;
      diff_q       <= diff_d;
      borrow_q     <= borrow_d;
      borrow_out_q <= borrow_out_d;
      cnt_q        <= cnt_d;
    end
  end

  assign in_ready   = (state_q == IDLE);
  assign out_valid  = (state_q == DONE);
  assign busy       = (state_q != IDLE);
  assign diff       = diff_q;
  assign borrow_out = borrow_out_q;

endmodule
